// File: rtl/uart_bus_master_if.sv
// rtl/uart_bus_master_if.sv - UART byte handshake and bus signal bundle for uart_bus_master
//
// Purpose: groups the RX/TX byte handshakes and the cyc/we/sel/addr/ack bus
// used by uart_bus_master.
// Modports:
//   master - the bus initiator (uart_bus_master): drives rx_pop, tx_data,
//            tx_available, cyc, we, sel, addr, data_out, owner.
//   slave  - the UART FIFOs plus bus responders: drive rx_data, rx_ack,
//            tx_ack, data_in, ack.
`timescale 1ns/1ps

interface uart_bus_master_if;
   logic [7:0]  rx_data;
   logic        rx_pop;
   logic        rx_ack;
   logic [7:0]  tx_data;
   logic        tx_available;
   logic        tx_ack;
   logic        cyc;
   logic        we;
   logic [3:0]  sel;
   logic [29:0] addr;
   logic [31:0] data_out;
   logic [31:0] data_in;
   logic        ack;
   logic        owner;

   modport master (
      input  rx_data, rx_ack, tx_ack, data_in, ack,
      output rx_pop, tx_data, tx_available, cyc, we, sel, addr, data_out, owner
   );

   modport slave (
      output rx_data, rx_ack, tx_ack, data_in, ack,
      input  rx_pop, tx_data, tx_available, cyc, we, sel, addr, data_out, owner
   );
endinterface

// File: rtl/uart_bus_master.sv
// rtl/uart_bus_master.sv - UART byte-stream driven single-word bus initiator
//
// Purpose: parses 'W' addr[4] data[4] / 'R' addr[4] frames (little-endian)
// from the UART RX FIFO, runs one bus cycle, and replies on the UART TX FIFO
// with 'K' (write done), four read-data bytes (LSB first) or 'E' (timeout).
// Optional macro UART_BUS_MASTER_TIMEOUT_EN enables the ack timeout counter;
// without it the bus cycle waits for ack indefinitely.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   bus    - uart_bus_master_if.master: rx_data/rx_pop/rx_ack,
//            tx_data/tx_available/tx_ack, cyc/we/sel/addr/data_out/data_in/ack,
//            owner (high from first address byte to end of response)
`timescale 1ns/1ps

module uart_bus_master #(
   parameter int          TIMEOUT   = 255,
   parameter logic [7:0]  CMD_WRITE = 8'h57,
   parameter logic [7:0]  CMD_READ  = 8'h52
) (
   input logic               clk,
   input logic               rst_n,
   uart_bus_master_if.master bus
);

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

   state_t      state_q, state_d;
   logic        write_q, write_d;
   logic        short_q, short_d;     // one-byte response ('K' or 'E')
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] shift_q, shift_d;     // frame assembly, then read data rotation
   logic        rx_pop_q, rx_pop_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        tx_avail_q, tx_avail_d;
   logic        cyc_q, cyc_d;
   logic        we_q, we_d;
   logic [3:0]  sel_q, sel_d;
   logic [29:0] addr_q, addr_d;
   logic [31:0] data_out_q, data_out_d;
   logic        owner_q, owner_d;
   logic        rx_fire, tx_fire;

`ifdef UART_BUS_MASTER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tmo_q, tmo_d;
`else
   // Keeps the parameter referenced while the counter is compiled out.
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT >= 1);
`endif

   assign rx_fire = rx_pop_q && bus.rx_ack;
   assign tx_fire = tx_avail_q && bus.tx_ack;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         write_q    <= 1'b0;
         short_q    <= 1'b0;
         cnt_q      <= 2'd0;
         shift_q    <= 32'd0;
         rx_pop_q   <= 1'b0;
         tx_data_q  <= 8'd0;
         tx_avail_q <= 1'b0;
         cyc_q      <= 1'b0;
         we_q       <= 1'b0;
         sel_q      <= 4'd0;
         addr_q     <= 30'd0;
         data_out_q <= 32'd0;
         owner_q    <= 1'b0;
`ifdef UART_BUS_MASTER_TIMEOUT_EN
         tmo_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         write_q    <= write_d;
         short_q    <= short_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         rx_pop_q   <= rx_pop_d;
         tx_data_q  <= tx_data_d;
         tx_avail_q <= tx_avail_d;
         cyc_q      <= cyc_d;
         we_q       <= we_d;
         sel_q      <= sel_d;
         addr_q     <= addr_d;
         data_out_q <= data_out_d;
         owner_q    <= owner_d;
`ifdef UART_BUS_MASTER_TIMEOUT_EN
         tmo_q      <= tmo_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      write_d    = write_q;
      short_d    = short_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      rx_pop_d   = 1'b0;
      tx_data_d  = tx_data_q;
      tx_avail_d = tx_avail_q;
      cyc_d      = cyc_q;
      we_d       = we_q;
      sel_d      = sel_q;
      addr_d     = addr_q;
      data_out_d = data_out_q;
      owner_d    = owner_q;
`ifdef UART_BUS_MASTER_TIMEOUT_EN
      tmo_d      = '0;
`endif

      case (state_q)
         S_IDLE: begin
            // Unknown bytes are dropped so the host can resynchronise.
            if (rx_fire) begin
               cnt_d = 2'd0;
               if (bus.rx_data == CMD_WRITE) begin
                  write_d = 1'b1;
                  state_d = S_ADDR;
               end else if (bus.rx_data == CMD_READ) begin
                  write_d = 1'b0;
                  state_d = S_ADDR;
               end
            end else begin
               rx_pop_d = 1'b1;
            end
         end

         S_ADDR: begin
            if (rx_fire) begin
               shift_d = {bus.rx_data, shift_q[31:8]};
               cnt_d   = cnt_q + 2'd1;
               owner_d = 1'b1;
               if (cnt_q == 2'd3) begin
                  addr_d = shift_d[31:2];
                  if (write_q) begin
                     state_d = S_DATA;
                  end else begin
                     state_d = S_BUS;
                     cyc_d   = 1'b1;
                     we_d    = 1'b0;
                     sel_d   = 4'hF;
                  end
               end
            end else begin
               rx_pop_d = 1'b1;
            end
         end

         S_DATA: begin
            if (rx_fire) begin
               shift_d = {bus.rx_data, shift_q[31:8]};
               cnt_d   = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  data_out_d = shift_d;
                  state_d    = S_BUS;
                  cyc_d      = 1'b1;
                  we_d       = 1'b1;
                  sel_d      = 4'hF;
               end
            end else begin
               rx_pop_d = 1'b1;
            end
         end

         S_BUS: begin
`ifdef UART_BUS_MASTER_TIMEOUT_EN
            tmo_d = tmo_q + TW'(1);
`endif
            // ack wins over a timeout landing on the same edge.
            if (bus.ack) begin
               cyc_d      = 1'b0;
               we_d       = 1'b0;
               sel_d      = 4'h0;
               cnt_d      = 2'd0;
               short_d    = write_q;
               tx_avail_d = 1'b1;
               state_d    = S_RESP;
               if (write_q) begin
                  tx_data_d = 8'h4B;
               end else begin
                  shift_d   = bus.data_in;
                  tx_data_d = bus.data_in[7:0];
               end
`ifdef UART_BUS_MASTER_TIMEOUT_EN
            end else if (tmo_d == TW'(TIMEOUT)) begin
               cyc_d      = 1'b0;
               we_d       = 1'b0;
               sel_d      = 4'h0;
               cnt_d      = 2'd0;
               short_d    = 1'b1;
               tx_avail_d = 1'b1;
               tx_data_d  = 8'h45;
               state_d    = S_RESP;
`endif
            end
         end

         S_RESP: begin
            if (tx_fire) begin
               tx_avail_d = 1'b0;
               cnt_d      = cnt_q + 2'd1;
               if (short_q || cnt_q == 2'd3) begin
                  owner_d = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  // Rotate so the next read byte lands in the low lane.
                  shift_d   = {shift_q[7:0], shift_q[31:8]};
                  tx_data_d = shift_d[7:0];
               end
            end else if (!tx_avail_q) begin
               tx_avail_d = 1'b1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign bus.rx_pop       = rx_pop_q;
   assign bus.tx_data      = tx_data_q;
   assign bus.tx_available = tx_avail_q;
   assign bus.cyc          = cyc_q;
   assign bus.we           = we_q;
   assign bus.sel          = sel_q;
   assign bus.addr         = addr_q;
   assign bus.data_out     = data_out_q;
   assign bus.owner        = owner_q;

endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- Byte-stream-driven bus initiator: a host-side debug/loader port that drives the same cyc/we/sel/addr/ack bus the CPU drives.
- Consumes command bytes from the UART receive interface and issues single-word read or write cycles to the bus responders (RAM, LED, UART registers).
- Returns results through the UART transmit interface.
- Top level muxes its bus outputs against the CPU's using the `owner` output.

Parameters:
- TIMEOUT, 255, bus cycles to wait for ack before aborting; must be >= 1.
- CMD_WRITE, 8'h57, command byte for a write ('W').
- CMD_READ, 8'h52, command byte for a read ('R').

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx_data  input  8  received byte, valid when rx_ack=1
- rx_pop  output  1  request one byte from the UART RX FIFO
- rx_ack  input  1  byte delivered on rx_data this cycle
- tx_data  output  8  byte to transmit
- tx_available  output  1  request to push tx_data into the UART TX FIFO
- tx_ack  input  1  TX FIFO accepted tx_data this cycle
- cyc  output  1  bus cycle active
- we  output  1  bus write
- sel  output  4  byte lanes; always 4'b1111 while cyc=1
- addr  output  30  word address (byte address [31:2])
- data_out  output  32  write data
- data_in  input  32  read data, valid when ack=1
- ack  input  1  bus acknowledge
- owner  output  1  high from the first accepted address byte to the end of the response

Behaviour:
- Reset (rst_n=0, asynchronous) forces all outputs to 0 and the state to IDLE; the shift registers, byte counter and timeout counter are all cleared.
- Reset mid-operation aborts any byte or bus handshake immediately, with no response.
- All outputs are registered.
- Byte handshake, RX:
  - rx_pop is held high while a byte is wanted.
  - At the edge where rx_pop&&rx_ack, rx_data is captured and rx_pop goes low for at least 1 cycle.
- Byte handshake, TX:
  - tx_available is held with tx_data stable until the edge where tx_ack=1.
  - tx_available then drops for at least 1 cycle.
- State IDLE:
  - Fetch one byte.
  - CMD_WRITE -> ADDR with write flag set; CMD_READ -> ADDR with write flag clear.
  - Any other byte is discarded and the block stays in IDLE (resynchronisation).
- State ADDR:
  - Fetch 4 bytes, little-endian, byte address.
  - addr = byte_addr[31:2]; byte_addr[1:0] is ignored.
  - owner rises on the edge capturing the first address byte.
  - Then -> DATA if writing, else -> BUS.
- State DATA: fetch 4 bytes, little-endian, into data_out; then -> BUS.
- State BUS:
  - cyc=1, we=write flag, sel=4'b1111; addr and data_out are held stable.
  - At the edge where ack=1: capture data_in (reads only), cyc goes low the next cycle, -> RESP.
  - Minimum bus latency is 1 cycle (ack in the first cyc cycle).
  - ack while cyc=0 is ignored.
- State RESP:
  - Write success sends 1 byte, 8'h4B ('K').
  - Read success sends 4 bytes, data_in[7:0] first.
  - Timeout (read or write) sends 1 byte, 8'h45 ('E').
  - After the last tx_ack, owner goes low and the state returns to IDLE.
- The byte counter is 2 bits and wraps after 4 bytes; there is no partial-frame timeout, so the host must complete each frame.
- RX bytes are never requested outside the IDLE, ADDR and DATA states.
- Back-to-back commands are allowed: rx_pop may rise in the cycle after owner falls.

Optional Feature:
- Macro: UART_BUS_MASTER_TIMEOUT_EN.
- Defined:
  - A counter increments each cycle of BUS.
  - If it reaches TIMEOUT without ack, cyc drops the next cycle, read data is discarded, and RESP sends 8'h45.
  - An ack arriving on the same edge the count reaches TIMEOUT counts as success.
- Undefined:
  - BUS waits for ack indefinitely.
  - The 8'h45 response is never generated and the counter logic is absent.

Test Plan:
- Write, ack after 2 cycles: RX 57, 00 04 00 00, 2A 00 00 00 -> one bus cycle with cyc=1, we=1, addr=30'h100, data_out=32'h0000002A, sel=4'hF; cyc low the cycle after ack; TX 4B; owner low afterwards.
- Read, immediate ack: RX 52, 08 08 00 00; responder acks in the first cycle with data_in=32'hDEADBEEF -> addr=30'h202, we=0; TX EF BE AD DE in that order.
- Garbage resync: RX 00 FF 52, 00 08 00 00 -> first two bytes discarded with no bus cycle and owner=0; read at addr=30'h200 proceeds normally.
- Timeout (macro defined, TIMEOUT=4), ack never asserted -> cyc high for exactly 4 cycles then low; TX 45; next command accepted. With the macro undefined, cyc stays high for 1000 cycles.
- Backpressure and reset: stall tx_ack for 10 cycles during a read response -> tx_data and tx_available are stable for the whole stall. Then pulse rst_n low during BUS -> cyc, owner, tx_available and rx_pop all 0 asynchronously, and a fresh write completes correctly after reset.
